// File: rtl/butterfly_pkg.sv
// butterfly_pkg: default widths plus fixed-point truncation and reduction helpers.
// Build option BUTTERFLY_SAT_EN turns wrapping reduction into saturation.
package butterfly_pkg;

    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 11;
    localparam int WW       = 64;

    typedef logic signed [WW-1:0] wide_t;

    // Arithmetic shift right that rounds toward zero instead of toward -inf.
    function automatic wide_t trunc_zero(wide_t p, int frac);
        wide_t bias;
        bias = p[WW-1] ? (wide_t'(1) <<< frac) - wide_t'(1) : '0;
        return (p + bias) >>> frac;
    endfunction

    function automatic logic fits(wide_t v, int dw);
        wide_t lim;
        lim = wide_t'(1) <<< (dw - 1);
        return (v < lim) && (v >= -lim);
    endfunction

    function automatic wide_t reduce(wide_t v, int dw);
`ifdef BUTTERFLY_SAT_EN
        wide_t lim;
        lim = wide_t'(1) <<< (dw - 1);
        if (v >= lim) return lim - wide_t'(1);
        if (v < -lim) return -lim;
        return v;
`else
        return (v <<< (WW - dw)) >>> (WW - dw);
`endif
    endfunction

endpackage

// File: rtl/butterfly_r2_pipe_if.sv
// butterfly_r2_pipe_if: operand/result valid-ready bundle of butterfly_r2_pipe.
// Unaffected by BUTTERFLY_SAT_EN.
interface butterfly_r2_pipe_if
    import butterfly_pkg::*;
#(
    parameter int DW = DW_DEF
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] x0;
    logic [2*DW-1:0] x1;
    logic [2*DW-1:0] tw;
    logic            inv;
    logic            scale;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] y0;
    logic [2*DW-1:0] y1;
    logic            ovf;

    modport slave (
        input  in_valid, x0, x1, tw, inv, scale, out_ready,
        output in_ready, out_valid, y0, y1, ovf
    );

    modport master (
        output in_valid, x0, x1, tw, inv, scale, out_ready,
        input  in_ready, out_valid, y0, y1, ovf
    );
endinterface

// File: rtl/cmul_pipe.sv
// cmul_pipe: S1 operand register with twiddle conjugation, S2 partial products.
// Both stages advance only while en is high; unaffected by BUTTERFLY_SAT_EN.
module cmul_pipe
    import butterfly_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [2*DW-1:0]      x0,
    input  logic [2*DW-1:0]      x1,
    input  logic [2*DW-1:0]      tw,
    input  logic                 inv,
    input  logic                 scale,
    output logic                 p_valid,
    output logic [2*DW-1:0]      p_x0,
    output logic                 p_scale,
    output logic signed [DW-1:0] rr,
    output logic signed [DW-1:0] ii,
    output logic signed [DW-1:0] ri,
    output logic signed [DW-1:0] ir
);
    logic                 s1_valid_q, s1_valid_d;
    logic [2*DW-1:0]      s1_x0_q, s1_x0_d;
    logic [2*DW-1:0]      s1_x1_q, s1_x1_d;
    logic [2*DW-1:0]      s1_w_q, s1_w_d;
    logic                 s1_scale_q, s1_scale_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [2*DW-1:0]      s2_x0_q, s2_x0_d;
    logic                 s2_scale_q, s2_scale_d;
    logic signed [DW-1:0] rr_q, rr_d, ii_q, ii_d;
    logic signed [DW-1:0] ri_q, ri_d, ir_q, ir_d;
    logic signed [DW-1:0] w_im;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;

    assign a_re = s1_x1_q[2*DW-1:DW];
    assign a_im = s1_x1_q[DW-1:0];
    assign b_re = s1_w_q[2*DW-1:DW];
    assign b_im = s1_w_q[DW-1:0];

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x0_d    = s1_x0_q;
        s1_x1_d    = s1_x1_q;
        s1_w_d     = s1_w_q;
        s1_scale_d = s1_scale_q;
        s2_valid_d = s2_valid_q;
        s2_x0_d    = s2_x0_q;
        s2_scale_d = s2_scale_q;
        rr_d = rr_q;
        ii_d = ii_q;
        ri_d = ri_q;
        ir_d = ir_q;
        w_im = tw[DW-1:0];
        if (inv) w_im = -tw[DW-1:0];
        if (en) begin
            s1_valid_d = in_valid;
            s1_x0_d    = x0;
            s1_x1_d    = x1;
            s1_w_d     = {tw[2*DW-1:DW], w_im};
            s1_scale_d = scale;
            s2_valid_d = s1_valid_q;
            s2_x0_d    = s1_x0_q;
            s2_scale_d = s1_scale_q;
            rr_d = DW'(trunc_zero(wide_t'(a_re) * wide_t'(b_re), FRAC));
            ii_d = DW'(trunc_zero(wide_t'(a_im) * wide_t'(b_im), FRAC));
            ri_d = DW'(trunc_zero(wide_t'(a_re) * wide_t'(b_im), FRAC));
            ir_d = DW'(trunc_zero(wide_t'(a_im) * wide_t'(b_re), FRAC));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_x0_q    <= '0;
            s1_x1_q    <= '0;
            s1_w_q     <= '0;
            s1_scale_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_x0_q    <= '0;
            s2_scale_q <= 1'b0;
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x0_q    <= s1_x0_d;
            s1_x1_q    <= s1_x1_d;
            s1_w_q     <= s1_w_d;
            s1_scale_q <= s1_scale_d;
            s2_valid_q <= s2_valid_d;
            s2_x0_q    <= s2_x0_d;
            s2_scale_q <= s2_scale_d;
            rr_q <= rr_d;
            ii_q <= ii_d;
            ri_q <= ri_d;
            ir_q <= ir_d;
        end
    end

    assign p_valid = s2_valid_q;
    assign p_x0    = s2_x0_q;
    assign p_scale = s2_scale_q;
    assign rr      = rr_q;
    assign ii      = ii_q;
    assign ri      = ri_q;
    assign ir      = ir_q;
endmodule

// File: rtl/butterfly_r2_pipe.sv
// butterfly_r2_pipe: 3-stage radix-2 complex butterfly with global stall.
// Define BUTTERFLY_SAT_EN for saturating (instead of wrapping) outputs.
module butterfly_r2_pipe
    import butterfly_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    butterfly_r2_pipe_if.slave bus
);
    logic                 en;
    logic                 p_valid, p_scale;
    logic [2*DW-1:0]      p_x0;
    logic signed [DW-1:0] rr, ii, ri, ir;
    logic                 out_valid_q, out_valid_d;
    logic [2*DW-1:0]      y0_q, y0_d, y1_q, y1_d;
    logic                 ovf_q, ovf_d;
    logic                 any_ovf;
    wide_t                m_re, m_im;
    wide_t                s [4];
    logic [DW-1:0]        r [4];

    assign en = !out_valid_q || bus.out_ready;

    cmul_pipe #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_cmul (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .in_valid (bus.in_valid),
        .x0       (bus.x0),
        .x1       (bus.x1),
        .tw       (bus.tw),
        .inv      (bus.inv),
        .scale    (bus.scale),
        .p_valid  (p_valid),
        .p_x0     (p_x0),
        .p_scale  (p_scale),
        .rr       (rr),
        .ii       (ii),
        .ri       (ri),
        .ir       (ir)
    );

    // Wide sums are exact, so they equal the DW+2-bit results.
    always_comb begin
        m_re = wide_t'(rr) - wide_t'(ii);
        m_im = wide_t'(ri) + wide_t'(ir);
        s[0] = wide_t'($signed(p_x0[2*DW-1:DW])) + m_re;
        s[1] = wide_t'($signed(p_x0[DW-1:0])) + m_im;
        s[2] = wide_t'($signed(p_x0[2*DW-1:DW])) - m_re;
        s[3] = wide_t'($signed(p_x0[DW-1:0])) - m_im;
        any_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (p_scale) s[i] = s[i] >>> 1;
            any_ovf = any_ovf | !fits(s[i], DW);
            r[i] = DW'(reduce(s[i], DW));
        end
        out_valid_d = out_valid_q;
        y0_d  = y0_q;
        y1_d  = y1_q;
        ovf_d = ovf_q;
        if (en) begin
            out_valid_d = p_valid;
            if (p_valid) begin
                y0_d  = {r[0], r[1]};
                y1_d  = {r[2], r[3]};
                ovf_d = ovf_q | any_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            y0_q        <= '0;
            y1_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.y0        = y0_q;
    assign bus.y1        = y1_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// tb_butterfly_r2_pipe: directed and randomized checks of butterfly_r2_pipe.
// Expected values follow BUTTERFLY_SAT_EN when it is defined for the build.
module tb_butterfly_r2_pipe;
    localparam int DW   = 16;
    localparam int FRAC = 11;

    typedef struct {
        logic [31:0] y0;
        logic [31:0] y1;
        bit          ovf;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    bit   model_ovf = 1'b0;
    res_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    butterfly_r2_pipe_if #(.DW(DW)) bus ();

    butterfly_r2_pipe #(
        .DW   (DW),
        .FRAC (FRAC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic longint sx(logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint wrap16(longint v);
        longint m;
        m = v & 64'hFFFF;
        if (m >= 32768) m = m - 65536;
        return m;
    endfunction

    function automatic longint red16(longint v);
`ifdef BUTTERFLY_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        return wrap16(v);
`endif
    endfunction

    // Reference: integer division truncates toward zero, as required.
    function automatic res_t model(logic [31:0] a, logic [31:0] b,
                                   logic [31:0] w, bit iv, bit sc);
        res_t   r;
        longint one, ar, ai, br, bi, wr, wi, rr, ii, ri, ir, mr, mi;
        longint y[4];
        one = longint'(1) << FRAC;
        ar = sx(a[31:16]);
        ai = sx(a[15:0]);
        br = sx(b[31:16]);
        bi = sx(b[15:0]);
        wr = sx(w[31:16]);
        wi = iv ? wrap16(-sx(w[15:0])) : sx(w[15:0]);
        rr = wrap16((br * wr) / one);
        ii = wrap16((bi * wi) / one);
        ri = wrap16((br * wi) / one);
        ir = wrap16((bi * wr) / one);
        mr = rr - ii;
        mi = ri + ir;
        y[0] = ar + mr;
        y[1] = ai + mi;
        y[2] = ar - mr;
        y[3] = ai - mi;
        r.ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sc) y[i] = y[i] >>> 1;
            if (y[i] > 32767 || y[i] < -32768) r.ovf = 1'b1;
            y[i] = red16(y[i]);
        end
        r.y0 = {16'(y[0]), 16'(y[1])};
        r.y1 = {16'(y[2]), 16'(y[3])};
        return r;
    endfunction

    task automatic drive(bit v, logic [31:0] a, logic [31:0] b,
                         logic [31:0] w, bit iv, bit sc);
        bus.in_valid = v;
        bus.x0 = a;
        bus.x1 = b;
        bus.tw = w;
        bus.inv = iv;
        bus.scale = sc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_ovf = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        else passed++;
        total++;
        if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got=%b want=0", bus.ovf);
        else passed++;
        total++;
        if (bus.y0 !== 32'h0 || bus.y1 !== 32'h0)
            $display("FAIL reset_y got=%h/%h want=0/0", bus.y0, bus.y1);
        else passed++;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        else passed++;
    endtask

    task automatic test_directed();
        logic [31:0] vx0[6] = '{32'h08000000, 32'h08000000, 32'h08000000,
                                32'h01000200, 32'h70000000, 32'h70000000};
        logic [31:0] vx1[6] = '{32'h04000000, 32'h04000000, 32'h04000000,
                                32'hFFFF0000, 32'h70000000, 32'h70000000};
        logic [31:0] vtw[6] = '{32'h08000000, 32'h0000F800, 32'h0000F800,
                                32'h04000000, 32'h08000000, 32'h08000000};
        bit          vinv[6] = '{0, 0, 1, 0, 0, 0};
        bit          vsc[6]  = '{0, 0, 0, 0, 1, 0};
        logic [31:0] ey0[6];
        logic [31:0] ey1[6] = '{32'h04000000, 32'h08000400, 32'h0800FC00,
                                32'h01000200, 32'h00000000, 32'h00000000};
        bit          eovf[6] = '{0, 0, 0, 0, 0, 1};
        ey0[0] = 32'h0C000000;
        ey0[1] = 32'h0800FC00;
        ey0[2] = 32'h08000400;
        ey0[3] = 32'h01000200;
        ey0[4] = 32'h70000000;
`ifdef BUTTERFLY_SAT_EN
        ey0[5] = 32'h7FFF0000;
`else
        ey0[5] = 32'hE0000000;
`endif
        for (int k = 0; k < 6; k++) begin
            int t0;
            int lat;
            bit seen;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            drive(1'b1, vx0[k], vx1[k], vtw[k], vinv[k], vsc[k]);
            t0 = cyc;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            seen = 1'b0;
            lat = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (bus.out_valid === 1'b1) begin
                    seen = 1'b1;
                    lat = cyc - t0;
                end
            end
            total++;
            if (!seen || lat != 3) $display("FAIL dir%0d_latency got=%0d seen=%0b want=3", k, lat, seen);
            else passed++;
            total++;
            if (bus.y0 !== ey0[k]) $display("FAIL dir%0d_y0 got=%h want=%h", k, bus.y0, ey0[k]);
            else passed++;
            total++;
            if (bus.y1 !== ey1[k]) $display("FAIL dir%0d_y1 got=%h want=%h", k, bus.y1, ey1[k]);
            else passed++;
            total++;
            if (bus.ovf !== eovf[k]) $display("FAIL dir%0d_ovf got=%b want=%b", k, bus.ovf, eovf[k]);
            else passed++;
        end
    endtask

    task automatic test_reset_midflight();
        int   bad;
        int   t0;
        int   lat;
        bit   seen;
        res_t e;
        logic [31:0] a, b, w;
        bit   iv, sc;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drive(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_ovf = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL flush_no_output got=%0d valid cycles want=0", bad);
        else passed++;
        total++;
        if (bus.ovf !== 1'b0) $display("FAIL flush_ovf_cleared got=%b want=0", bus.ovf);
        else passed++;
        a = $urandom;
        b = $urandom;
        w = $urandom;
        iv = ($urandom_range(0, 1) == 1);
        sc = ($urandom_range(0, 1) == 1);
        e = model(a, b, w, iv, sc);
        @(posedge clk);
        #1 drive(1'b1, a, b, w, iv, sc);
        t0 = cyc;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        seen = 1'b0;
        lat = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                lat = cyc - t0;
            end
        end
        total++;
        if (!seen || lat != 3) $display("FAIL post_reset_latency got=%0d seen=%0b want=3", lat, seen);
        else passed++;
        total++;
        if (bus.y0 !== e.y0 || bus.y1 !== e.y1)
            $display("FAIL post_reset_y got=%h/%h want=%h/%h", bus.y0, bus.y1, e.y0, e.y1);
        else passed++;
        model_ovf = model_ovf | e.ovf;
        total++;
        if (bus.ovf !== model_ovf) $display("FAIL post_reset_ovf got=%b want=%b", bus.ovf, model_ovf);
        else passed++;
    endtask

    task automatic test_stall();
        int   sent, got;
        bit   hold, pstall, iv, sc;
        logic [31:0] a, b, w, py0, py1;
        res_t e;
        sent = 0;
        got = 0;
        hold = 1'b0;
        pstall = 1'b0;
        py0 = '0;
        py1 = '0;
        a = '0;
        b = '0;
        w = '0;
        iv = 1'b0;
        sc = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 200 && got < 8; c++) begin
            @(posedge clk);
            #1;
            bus.out_ready = (c % 3 == 0);
            if (!hold) begin
                if (sent < 8) begin
                    a = $urandom;
                    b = $urandom;
                    w = $urandom;
                    iv = ($urandom_range(0, 1) == 1);
                    sc = ($urandom_range(0, 1) == 1);
                    drive(1'b1, a, b, w, iv, sc);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            total++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready))
                $display("FAIL stall_in_ready c=%0d got=%b want=%b", c, bus.in_ready,
                         !bus.out_valid || bus.out_ready);
            else passed++;
            if (pstall) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.y0 !== py0 || bus.y1 !== py1)
                    $display("FAIL stall_hold c=%0d got=%b %h/%h want=1 %h/%h", c,
                             bus.out_valid, bus.y0, bus.y1, py0, py1);
                else passed++;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stall_extra_output got=%h/%h want=none", bus.y0, bus.y1);
                end else begin
                    passed++;
                    e = exp_q.pop_front();
                    model_ovf = model_ovf | e.ovf;
                    got++;
                    total++;
                    if (bus.y0 !== e.y0 || bus.y1 !== e.y1)
                        $display("FAIL stall_result%0d got=%h/%h want=%h/%h", got,
                                 bus.y0, bus.y1, e.y0, e.y1);
                    else passed++;
                    total++;
                    if (bus.ovf !== model_ovf)
                        $display("FAIL stall_ovf%0d got=%b want=%b", got, bus.ovf, model_ovf);
                    else passed++;
                end
            end
            pstall = bus.out_valid && !bus.out_ready;
            py0 = bus.y0;
            py1 = bus.y1;
            hold = bus.in_valid && !bus.in_ready;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(a, b, w, iv, sc));
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        total++;
        if (got != 8 || exp_q.size() != 0)
            $display("FAIL stall_count got=%0d left=%0d want=8/0", got, exp_q.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        int   sent, got, last_c, not_ready;
        logic [31:0] a, b, w;
        bit   iv, sc;
        res_t e;
        sent = 0;
        got = 0;
        last_c = -1;
        not_ready = 0;
        a = '0;
        b = '0;
        w = '0;
        iv = 1'b0;
        sc = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 60 && got < 20; c++) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            if (sent < 20) begin
                a = $urandom;
                b = $urandom;
                w = $urandom;
                iv = ($urandom_range(0, 1) == 1);
                sc = ($urandom_range(0, 1) == 1);
                drive(1'b1, a, b, w, iv, sc);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.in_ready !== 1'b1) not_ready++;
            if (bus.out_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra_output got=%h/%h want=none", bus.y0, bus.y1);
                end else begin
                    e = exp_q.pop_front();
                    model_ovf = model_ovf | e.ovf;
                    got++;
                    last_c = c;
                    if (bus.y0 !== e.y0 || bus.y1 !== e.y1 || bus.ovf !== model_ovf)
                        $display("FAIL b2b_result%0d got=%h/%h/%b want=%h/%h/%b", got,
                                 bus.y0, bus.y1, bus.ovf, e.y0, e.y1, model_ovf);
                    else passed++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(a, b, w, iv, sc));
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        total++;
        if (not_ready != 0) $display("FAIL b2b_in_ready got=%0d low cycles want=0", not_ready);
        else passed++;
        total++;
        if (got != 20 || last_c != 22)
            $display("FAIL b2b_throughput got=%0d results last_cycle=%0d want=20 at 22", got, last_c);
        else passed++;
    endtask

    initial begin
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_reset_midflight();
        test_stall();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/butterfly_r2_pipe.md
BUTTERFLY_R2_PIPE -- requirements
Module: butterfly_r2_pipe

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the width of each real/imag component (two's complement).
REQ-002 SHALL have parameter FRAC, default 11, meaning the number of fractional bits of the twiddle and data (Q(DW-FRAC).FRAC).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  x0/x1/tw/inv/scale carry a valid butterfly operand set.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 x0, x1, tw  input  2*DW each  complex operands packed {re, im}, re in the upper DW bits.
REQ-008 inv  input  1  1 = use conj(tw) (inverse transform).
REQ-009 scale  input  1  1 = arithmetic shift right by 1 of both outputs (per-stage 1/2 scaling).
REQ-010 out_valid  output  1  y0/y1 hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 y0, y1  output  2*DW each  packed {re, im}: y0 = x0 + x1*w, y1 = x0 - x1*w.
REQ-013 ovf  output  1  sticky flag: some result component overflowed DW bits since reset.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 registers operands and applies conj; S2 registers the four partial products; S3 combines, adds/subtracts, scales, and registers the outputs.
REQ-015 Latency SHALL be exactly 3 cycles from an accepted input (in_valid & in_ready) to out_valid, with no stall.
REQ-016 in_ready SHALL equal !out_valid | out_ready; all three stages advance only when in_ready = 1 (global stall).
REQ-017 While stalled, y0/y1/out_valid SHALL hold their values; no operand set is dropped or duplicated.
REQ-018 Throughput SHALL be one butterfly per cycle when out_ready stays 1.
REQ-019 Per-stage valid bits SHALL propagate bubbles; out_valid = 0 for empty S3.
REQ-020 inv = 1 SHALL negate tw.im in S1 (two's complement; -min wraps to min).
REQ-021 Each partial product SHALL be a full 2*DW signed product, reduced to DW bits [FRAC+DW-1:FRAC] with truncation toward zero.
REQ-022 m.re = rr - ii, m.im = ri + ir SHALL be computed at DW+2 bits; y = x0 +/- m SHALL be computed at DW+2 bits, then shifted right by 1 if scale = 1, then reduced to DW bits.
REQ-023 ovf SHALL be set when any reduced component differs from its DW+2-bit value; it is cleared only by reset.
REQ-024 Simultaneous in_valid and out_ready with a full pipe SHALL accept the input and emit the output in the same cycle.

Reset
REQ-025 On reset: all stage valid bits, out_valid, and ovf = 0; y0 = y1 = 0; in_ready = 1 in the following cycle.
REQ-026 Reset mid-operation SHALL discard all in-flight operands; no output is produced for them.

Configuration
REQ-027 Macro BUTTERFLY_SAT_EN: when defined, reduction to DW bits SHALL saturate to +(2^(DW-1)-1) / -2^(DW-1); when undefined, it SHALL wrap (discard the upper bits). ovf behaves identically in both cases.

Structure
REQ-028 Package butterfly_pkg SHALL hold default DW/FRAC constants and the trunc-to-zero and saturate/wrap reduction functions.
REQ-029 Sub-module cmul_pipe SHALL implement S1-S2 (conj and products) with its own stall enable input.

Verification (DW=16, FRAC=11, 1.0 = 0x0800)
REQ-030 x0=(0x0800,0), x1=(0x0400,0), tw=(0x0800,0), inv=0 -> after 3 cycles y0=(0x0C00,0), y1=(0x0400,0), ovf=0.
REQ-031 Same x0/x1, tw=(0,0xF800) (-j): inv=0 -> y0=(0x0800,0xFC00), y1=(0x0800,0x0400); inv=1 -> y0=(0x0800,0x0400), y1=(0x0800,0xFC00).
REQ-032 x0=x1=(0x7000,0), tw=1.0, scale=0 -> ovf=1; y0.re=0x7FFF with BUTTERFLY_SAT_EN, 0xE000 without; y1=(0,0). With scale=1 -> y0=(0x7000,0), ovf=0.
REQ-033 Negative truncation: x1=(0xFFFF,0), tw=(0x0400,0) -> m.re=0 (toward zero, not -1); y0 = x0.
REQ-034 Stream 8 operand sets with out_ready toggled 1,0,0,1,... -> all 8 results emitted in order, outputs held during stalls, in_ready = !out_valid | out_ready every cycle.
REQ-035 Assert reset with 2 sets in flight -> no out_valid for them; next accepted set emerges exactly 3 cycles after acceptance.
